// File: rtl/vitdec_pkg.sv
// Shared constants and helpers for the K=3, rate-1/2 hard-decision Viterbi decoder.
package vitdec_pkg;

    localparam int K       = 3;
    localparam int NSTATES = 4;

    localparam logic [K-1:0] G1 = 3'b101;
    localparam logic [K-1:0] G0 = 3'b111;

    // Expected code symbol {z1, z0} for input bit x with register contents {p1, p2}.
    function automatic logic [1:0] exp_symbol(input logic x, input logic p1, input logic p2);
        logic [K-1:0] taps;
        taps = {x, p1, p2};
        return {^(taps & G1), ^(taps & G0)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/vitdec_acs.sv
// Add-compare-select for one trellis state; sums are widened by two bits for normalisation.
module vitdec_acs #(
    parameter int PM_W = 4
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      bm0_i,
    input  logic [1:0]      bm1_i,
    output logic [PM_W+1:0] sum_o,
    output logic            dec_o
);

    logic [PM_W+1:0] cand0;
    logic [PM_W+1:0] cand1;

    assign cand0 = {2'b00, pm0_i} + {{PM_W{1'b0}}, bm0_i};
    assign cand1 = {2'b00, pm1_i} + {{PM_W{1'b0}}, bm1_i};

    // Strict compare so a tie keeps the predecessor whose oldest bit is 0.
    assign dec_o = (cand1 < cand0);
    assign sum_o = dec_o ? cand1 : cand0;

endmodule

// File: rtl/viterbi_dec.sv
// Four-state register-exchange Viterbi decoder with decision depth TB_DEPTH.
// Optional tail drain on the flush input is built when VITDEC_FLUSH_EN is defined.
module viterbi_dec
    import vitdec_pkg::*;
#(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [1:0] z_in,
`ifdef VITDEC_FLUSH_EN
    input  logic       flush,
`endif
    output logic       out_valid,
    output logic       x_out
);

    localparam int                CNT_W   = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(TB_DEPTH);
    localparam logic [PM_W-1:0]   PM_MAX  = '1;
    localparam logic [PM_W-1:0]   PM_HALF = {1'b1, {(PM_W-1){1'b0}}};

    typedef logic [PM_W-1:0]     pm_t;
    typedef logic [TB_DEPTH-1:0] surv_t;

    function automatic pm_t pm_init(input int s);
        return (s == 0) ? '0 : PM_HALF;
    endfunction

    pm_t   pm_q     [NSTATES];
    pm_t   pm_d     [NSTATES];
    pm_t   pm_cur   [NSTATES];
    pm_t   pm_upd   [NSTATES];
    surv_t surv_q   [NSTATES];
    surv_t surv_d   [NSTATES];
    surv_t surv_cur [NSTATES];
    surv_t surv_upd [NSTATES];

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_cur;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             x_out_q;
    logic             x_out_d;

    logic [PM_W+1:0]  sum [NSTATES];
    logic             dec [NSTATES];
    logic [PM_W+1:0]  sum_min;
    logic [1:0]       best;
    logic             best_bit;

`ifdef VITDEC_FLUSH_EN
    logic [CNT_W-1:0] drain_q;
    logic [CNT_W-1:0] drain_d;
    logic [CNT_W-1:0] drain_cur;

    assign drain_cur = start ? '0 : drain_q;
`endif

    // A start pulse replaces the stored state so a same-cycle symbol sees the initial metrics.
    always_comb begin
        for (int s = 0; s < NSTATES; s++) begin
            pm_cur[s]   = start ? pm_init(s) : pm_q[s];
            surv_cur[s] = start ? '0 : surv_q[s];
        end
        cnt_cur = start ? '0 : cnt_q;
    end

    // State ns = {b1, b0} is reached from {b0, 0} and {b0, 1} with hypothesised bit b1.
    for (genvar ns = 0; ns < NSTATES; ns++) begin : g_acs
        localparam int   P0 = (ns % 2) * 2;
        localparam int   P1 = P0 + 1;
        localparam logic X  = 1'(ns / 2);
        localparam logic B0 = 1'(ns % 2);

        logic [1:0] bm0;
        logic [1:0] bm1;

        assign bm0 = hamming2(z_in, exp_symbol(X, B0, 1'b0));
        assign bm1 = hamming2(z_in, exp_symbol(X, B0, 1'b1));

        vitdec_acs #(.PM_W(PM_W)) u_acs (
            .pm0_i (pm_cur[P0]),
            .pm1_i (pm_cur[P1]),
            .bm0_i (bm0),
            .bm1_i (bm1),
            .sum_o (sum[ns]),
            .dec_o (dec[ns])
        );
    end

    always_comb begin
        logic [PM_W+1:0] diff;
        logic [1:0]      pred;

        // NOTE: every variable driven here gets a value on every path, otherwise a latch is inferred.
        diff    = '0;
        pred    = '0;
        sum_min = sum[0];
        for (int s = 1; s < NSTATES; s++) begin
            if (sum[s] < sum_min) sum_min = sum[s];
        end

        for (int s = 0; s < NSTATES; s++) begin
            diff        = sum[s] - sum_min;
            pm_upd[s]   = (diff > {2'b00, PM_MAX}) ? PM_MAX : diff[PM_W-1:0];
            pred        = {s[0], dec[s]};
            surv_upd[s] = {surv_cur[pred][TB_DEPTH-2:0], s[1]};
        end

        // Decision uses the metrics before this symbol's update; ties go to the lowest state.
        best = '0;
        for (int s = 1; s < NSTATES; s++) begin
            if (pm_cur[s] < pm_cur[best]) best = 2'(s);
        end
        best_bit = surv_cur[best][TB_DEPTH-1];
    end

    always_comb begin
        pm_d        = pm_cur;
        surv_d      = surv_cur;
        cnt_d       = cnt_cur;
        out_valid_d = 1'b0;
        x_out_d     = x_out_q;
`ifdef VITDEC_FLUSH_EN
        drain_d     = drain_cur;
`endif
        if (in_valid) begin
            pm_d        = pm_upd;
            surv_d      = surv_upd;
            out_valid_d = (cnt_cur == DEPTH_C);
            if (cnt_cur != DEPTH_C) cnt_d = cnt_cur + CNT_W'(1);
            if (cnt_cur == DEPTH_C) x_out_d = best_bit;
        end
`ifdef VITDEC_FLUSH_EN
        else if (flush && (drain_cur < cnt_cur)) begin
            for (int s = 0; s < NSTATES; s++) begin
                surv_d[s] = {surv_cur[s][TB_DEPTH-2:0], 1'b0};
            end
            drain_d     = drain_cur + CNT_W'(1);
            out_valid_d = 1'b1;
            x_out_d     = best_bit;
        end
`endif
    end

    // NOTE: survivors live in flops rather than RAM, so they take their init value on reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSTATES; s++) begin
                pm_q[s]   <= pm_init(s);
                surv_q[s] <= '0;
            end
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            x_out_q     <= 1'b0;
`ifdef VITDEC_FLUSH_EN
            drain_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            pm_q        <= pm_d;
            surv_q      <= surv_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            x_out_q     <= x_out_d;
`ifdef VITDEC_FLUSH_EN
            drain_q     <= drain_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;

endmodule

// File: tb/tb_viterbi_dec.sv
// Scoreboard bench for viterbi_dec: the driver queues expected bits, a monitor pops on out_valid.
`timescale 1ns/1ps
module tb_viterbi_dec;

    localparam int D   = 16;
    localparam int PMW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [1:0] z_in;
    logic       out_valid;
    logic       x_out;
`ifdef VITDEC_FLUSH_EN
    logic       flush;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q [$];
    logic hist  [$];
    logic [1:0] enc_st;
    logic acc_q = 1'b0;

    always #5 clk = ~clk;

    viterbi_dec #(.TB_DEPTH(D), .PM_W(PMW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .z_in      (z_in),
`ifdef VITDEC_FLUSH_EN
        .flush     (flush),
`endif
        .out_valid (out_valid),
        .x_out     (x_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Remember whether the last edge had a reason to produce an output.
    always @(posedge clk) begin
`ifdef VITDEC_FLUSH_EN
        acc_q <= rst_n && (in_valid || flush);
`else
        acc_q <= rst_n && in_valid;
`endif
    end

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            check("valid_on_active_cycle", 32'(acc_q), 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: out_valid=1 x_out=%0b, expected no output (t=%0t)", x_out, $time);
            end else begin
                check("x_out", 32'(x_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            z_in     = 2'b00;
        end
    endtask

    // Drive one symbol; the bit D symbols back in this frame becomes an expected output.
    task automatic send(input logic [1:0] z, input logic x, input logic st);
        @(negedge clk);
        start    = st;
        in_valid = 1'b1;
        z_in     = z;
        if (st) hist.delete();
        hist.push_back(x);
        if (hist.size() > D) exp_q.push_back(hist[hist.size() - 1 - D]);
    endtask

    task automatic send_bit(input logic x, input logic st, input logic [1:0] err);
        logic [1:0] z;
        if (st) enc_st = 2'b00;
        z      = {x ^ enc_st[0], x ^ enc_st[1] ^ enc_st[0]} ^ err;
        enc_st = {x, enc_st[1]};
        send(z, x, st);
    endtask

    task automatic run_bits(input logic [63:0] bits, input int n, input logic st_first,
                            input int err_at, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 3));
            send_bit(bits[i], st_first && (i == 0), (i == err_at) ? 2'b10 : 2'b00);
        end
    endtask

    task automatic expect_drained(input string name);
        idle(3);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_mid_frame();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        enc_st   = 2'b00;
        hist.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_x_out", 32'(x_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] clean_sym [6];
        logic [3:0] clean_bits;

        clean_sym  = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
        clean_bits = 4'b1101;
        rst_n      = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        z_in       = 2'b00;
        enc_st     = 2'b00;
`ifdef VITDEC_FLUSH_EN
        flush      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_x_out", 32'(x_out), 32'd0);
        rst_n = 1'b1;

        // Hand-encoded frame 1,0,1,1,0,0,...
        for (int i = 0; i < 40; i++)
            send((i < 6) ? clean_sym[i] : 2'b00, (i < 4) ? clean_bits[i] : 1'b0, i == 0);
        expect_drained("clean_drained");

        run_bits(64'h0, 40, 1'b1, -1, 1'b0);
        expect_drained("zero_drained");
        check("zero_pm0", 32'(dut.pm_q[0]), 32'd0);

        run_bits(64'hD, 40, 1'b1, 2, 1'b0);
        expect_drained("single_err_drained");

        run_bits(64'h9A3C_51E7_24BD, 48, 1'b1, -1, 1'b1);
        expect_drained("gaps_drained");

        // Start pulse lands with symbol 20 of a running frame.
        run_bits(64'hC3A5_F00F, 20, 1'b1, -1, 1'b0);
        run_bits(64'h5E_6B2D_A71C_4F39, 40, 1'b1, -1, 1'b0);
        expect_drained("restart_drained");

        run_bits(64'h8F3B_61AD, 20, 1'b1, -1, 1'b0);
        reset_mid_frame();
        run_bits(64'h7_1D4E_9B02_C6F5, 40, 1'b0, -1, 1'b0);
        expect_drained("midrst_drained");

`ifdef VITDEC_FLUSH_EN
        run_bits(64'hB_6E29, 20, 1'b1, -1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            flush    = 1'b1;
            if (k == 0) begin
                for (int j = 4; j < 20; j++) exp_q.push_back(hist[j]);
            end
        end
        @(negedge clk);
        flush = 1'b0;
        expect_drained("flush_drained");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
